// File: rtl/eth_10g_tx_pkg.sv
// Shared constants for the 10G MAC transmit streaming blocks.
// Default widths used by the splitter and its holding slots.
package eth_10g_tx_pkg;
   localparam int DATA_W_DEF = 72;
   localparam int CNT_W_DEF  = 32;
endpackage

// File: rtl/eth_10g_st_hold_slot.sv
// One-entry output holding register: valid flag plus data, driven from Q.
// A reload wins over a drain in the same cycle, so throughput stays 1/cycle.
module eth_10g_st_hold_slot
   import eth_10g_tx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_data_i,
   input  logic              ready_i,
   output logic              free_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = load_data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign free_o  = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/eth_10g_mac_tx_st_splitter_buf.sv
// Registered 1-to-2 stream splitter; the secondary sink is optional via out1_en.
// Counts accepted beats and upstream stall cycles.
module eth_10g_mac_tx_st_splitter_buf
   import eth_10g_tx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   input  logic              out1_en,
   output logic [CNT_W-1:0]  beat_count,
   output logic [CNT_W-1:0]  stall_count
);

   localparam logic [CNT_W-1:0] ONE = 1;

   logic             free0, free1;
   logic             accept;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   // A disabled secondary sink never back-pressures, even if it still drains.
   assign in_ready = !reset && free0 && (free1 || !out1_en);
   assign accept   = in_valid && in_ready;

   eth_10g_st_hold_slot #(.DATA_W(DATA_W)) u_slot0 (
      .clk         (clk),
      .reset       (reset),
      .load_i      (accept),
      .load_data_i (in_data),
      .ready_i     (out0_ready),
      .free_o      (free0),
      .valid_o     (out0_valid),
      .data_o      (out0_data)
   );

   eth_10g_st_hold_slot #(.DATA_W(DATA_W)) u_slot1 (
      .clk         (clk),
      .reset       (reset),
      .load_i      (accept && out1_en),
      .load_data_i (in_data),
      .ready_i     (out1_ready),
      .free_o      (free1),
      .valid_o     (out1_valid),
      .data_o      (out1_data)
   );

   always_comb begin
      beat_d  = beat_q;
      stall_d = stall_q;
      if (accept)
         beat_d = beat_q + ONE;
      if (in_valid && !in_ready)
         stall_d = stall_q + ONE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q  <= '0;
         stall_q <= '0;
      end else begin
         beat_q  <= beat_d;
         stall_q <= stall_d;
      end
   end

   assign beat_count  = beat_q;
   assign stall_count = stall_q;

endmodule
